junction_phase_scheduler: RTL and testbench

//  Phase scheduler for a main-road / country-road junction. Shares green time between

---
 rtl/junction_phase_scheduler_pkg.sv | 49 ++++
 rtl/junction_phase_scheduler_phase_timer.sv | 47 ++++
 rtl/junction_phase_scheduler.sv | 149 ++++++++++++++
 tb/tb_junction_phase_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/junction_phase_scheduler_pkg.sv
// Shared definitions for the junction phase scheduler: boolean and lamp
// codes, phase (state) and next-phase encodings, and the lamp decode helper.
package junction_phase_scheduler_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  typedef enum logic [2:0] {
    MAIN_GRN  = 3'd0,
    MAIN_YEL  = 3'd1,
    ALL_RED   = 3'd2,
    CNTRY_GRN = 3'd3,
    CNTRY_YEL = 3'd4,
    PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    NXT_MAIN  = 2'd0,
    NXT_CNTRY = 2'd1,
    NXT_PED   = 2'd2
  } next_ph_e;

  typedef struct packed {
    logic [1:0] main;
    logic [1:0] cntry;
    logic       walk;
  } lamps_t;

  // Moore lamp decode; anything unrecognised shows all-red with walk off.
  function automatic lamps_t lamps_of(input phase_e ph);
    lamps_t l;
    l = '{main: LAMP_RED, cntry: LAMP_RED, walk: FALSE};
    case (ph)
      MAIN_GRN:  l = '{main: LAMP_GREEN,  cntry: LAMP_RED,    walk: FALSE};
      MAIN_YEL:  l = '{main: LAMP_YELLOW, cntry: LAMP_RED,    walk: FALSE};
      ALL_RED:   l = '{main: LAMP_RED,    cntry: LAMP_RED,    walk: FALSE};
      CNTRY_GRN: l = '{main: LAMP_RED,    cntry: LAMP_GREEN,  walk: FALSE};
      CNTRY_YEL: l = '{main: LAMP_RED,    cntry: LAMP_YELLOW, walk: FALSE};
      PED_WALK:  l = '{main: LAMP_RED,    cntry: LAMP_RED,    walk: TRUE};
      default:   l = '{main: LAMP_RED,    cntry: LAMP_RED,    walk: FALSE};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/junction_phase_scheduler_phase_timer.sv
// phase_timer: CNT_W-bit counter cleared on phase entry, +1 per cycle,
// saturating at all-ones.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset (count = 0)
//   clr_i  - synchronous clear (a new phase is being entered this edge)
//   cnt_o  - cycles spent in the current phase so far
module phase_timer
  import junction_phase_scheduler_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i == TRUE) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: shares green time at a main-road / country-road
// junction between the country car sensor, the pedestrian button and an
// emergency preempt. Main road rests on green.
// Ports:
//   clock     - clock, rising edge
//   clear     - asynchronous active-low reset
//   car_cntry - level, vehicle waiting on the country road
//   ped_req   - pedestrian button (pulse is latched)
//   emerg     - level, emergency vehicle on main road (preempts everything)
//   main      - main-road lamp (RED/YELLOW/GREEN = 0/1/2)
//   cntry     - country-road lamp, same encoding
//   walk      - pedestrian walk lamp
//   phase     - current state encoding for observation
module junction_phase_scheduler
  import junction_phase_scheduler_pkg::*;
#(
  parameter int CNT_W       = 5,
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 16,
  parameter int Y_CYCLES    = 3,
  parameter int AR_CYCLES   = 2,
  parameter int WALK_CYCLES = 10
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       car_cntry,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [1:0] main,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] phase
);

  // Timer value on the last cycle of each duration (timer starts at 0 on entry).
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);

  phase_e           state_q, state_d;
  next_ph_e         next_ph_q, next_ph_d;
  logic             ped_pend_q, ped_pend_d;
  lamps_t           lamps_q;
  logic [CNT_W-1:0] timer_s;
  logic             entry_s;

  assign entry_s = (state_d != state_q);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (clock),
    .rst_ni (clear),
    .clr_i  (entry_s),
    .cnt_o  (timer_s)
  );

  // Next-phase selection and the phase that follows the all-red clearance.
  always_comb begin
    state_d   = state_q;
    next_ph_d = next_ph_q;
    case (state_q)
      MAIN_GRN: begin
        if (emerg) begin
          state_d = MAIN_GRN;
        end else if ((timer_s >= MIN_LAST) && (car_cntry || ped_pend_q)) begin
          next_ph_d = car_cntry ? NXT_CNTRY : NXT_PED;
          state_d   = MAIN_YEL;
        end else begin
          state_d = MAIN_GRN;
        end
      end
      MAIN_YEL: begin
        if (timer_s >= Y_LAST) state_d = ALL_RED;
        else                   state_d = MAIN_YEL;
      end
      ALL_RED: begin
        if (timer_s < AR_LAST) begin
          state_d = ALL_RED;
        end else if (emerg) begin
          state_d = MAIN_GRN;
        end else begin
          case (next_ph_q)
            NXT_CNTRY: state_d = CNTRY_GRN;
            NXT_PED:   state_d = PED_WALK;
            NXT_MAIN:  state_d = MAIN_GRN;
            default:   state_d = MAIN_GRN;
          endcase
        end
      end
      CNTRY_GRN: begin
        // Emergency cuts country green short, ignoring the minimum.
        if (emerg || ((timer_s >= MIN_LAST) && !car_cntry) || (timer_s >= MAX_LAST)) begin
          next_ph_d = (ped_pend_q && !emerg) ? NXT_PED : NXT_MAIN;
          state_d   = CNTRY_YEL;
        end else begin
          state_d = CNTRY_GRN;
        end
      end
      CNTRY_YEL: begin
        if (timer_s >= Y_LAST) state_d = ALL_RED;
        else                   state_d = CNTRY_YEL;
      end
      PED_WALK: begin
        if (emerg || (timer_s >= WALK_LAST)) begin
          next_ph_d = NXT_MAIN;
          state_d   = ALL_RED;
        end else begin
          state_d = PED_WALK;
        end
      end
      // Unused encodings recover through a yellow and the clearance interval.
      default: state_d = MAIN_YEL;
    endcase
  end

  // Pedestrian latch: a press on the edge entering the walk is the one being served.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
      ped_pend_d = FALSE;
    end else if ((state_q != PED_WALK) && ped_req) begin
      ped_pend_d = TRUE;
    end else begin
      ped_pend_d = ped_pend_q;
    end
  end

  // State, latch and registered lamp decode of the state being entered.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= MAIN_GRN;
      next_ph_q  <= NXT_MAIN;
      ped_pend_q <= FALSE;
      lamps_q    <= lamps_of(MAIN_GRN);
    end else begin
      state_q    <= state_d;
      next_ph_q  <= next_ph_d;
      ped_pend_q <= ped_pend_d;
      lamps_q    <= lamps_of(state_d);
    end
  end

  assign main  = lamps_q.main;
  assign cntry = lamps_q.cntry;
  assign walk  = lamps_q.walk;
  assign phase = state_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Self-checking bench for junction_phase_scheduler: directed scenarios with
// timeline spot checks, then randomized traffic, all compared every cycle
// against a phase/age reference model.
module tb_junction_phase_scheduler;
  import junction_phase_scheduler_pkg::*;

  logic       clock;
  logic       clear;
  logic       car_cntry;
  logic       ped_req;
  logic       emerg;
  logic [1:0] main;
  logic [1:0] cntry;
  logic       walk;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;

  // Model phases and durations (cycles).
  localparam int P_MG = 0, P_MY = 1, P_AR = 2, P_CG = 3, P_CY = 4, P_PW = 5;
  localparam int D_MIN = 8, D_MAX = 16, D_Y = 3, D_AR = 2, D_WALK = 10;
  localparam int A_MAIN = 0, A_CNTRY = 1, A_PED = 2;

  int m_ph, m_age, m_after;
  bit m_pend;

  typedef struct {
    int         c;
    logic [1:0] m;
    logic [1:0] k;
    logic       w;
  } spot_t;
  spot_t spots[$];

  junction_phase_scheduler dut (
    .clock     (clock),
    .clear     (clear),
    .car_cntry (car_cntry),
    .ped_req   (ped_req),
    .emerg     (emerg),
    .main      (main),
    .cntry     (cntry),
    .walk      (walk),
    .phase     (phase)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_lamps(input int ph);
    case (ph)
      P_MG:    return {G, R, 1'b0};
      P_MY:    return {Y, R, 1'b0};
      P_CG:    return {R, G, 1'b0};
      P_CY:    return {R, Y, 1'b0};
      P_PW:    return {R, R, 1'b1};
      default: return {R, R, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_ph = P_MG; m_age = 0; m_after = A_MAIN; m_pend = 1'b0;
  endtask

  // One clock of the junction rules given this cycle's inputs.
  task automatic model_step(input bit car, input bit ped, input bit em);
    int nxt;
    int done;
    nxt  = m_ph;
    done = m_age + 1;
    case (m_ph)
      P_MG: if (!em && done >= D_MIN && (car || m_pend)) begin
              m_after = car ? A_CNTRY : A_PED; nxt = P_MY;
            end
      P_MY: if (done >= D_Y) nxt = P_AR;
      P_AR: if (done >= D_AR) begin
              if (em) nxt = P_MG;
              else nxt = (m_after == A_CNTRY) ? P_CG : (m_after == A_PED) ? P_PW : P_MG;
            end
      P_CG: if (em || (done >= D_MIN && !car) || done >= D_MAX) begin
              m_after = (m_pend && !em) ? A_PED : A_MAIN; nxt = P_CY;
            end
      P_CY: if (done >= D_Y) nxt = P_AR;
      P_PW: if (em || done >= D_WALK) begin
              m_after = A_MAIN; nxt = P_AR;
            end
      default: nxt = P_MY;
    endcase
    if (nxt == P_PW && m_ph != P_PW) m_pend = 1'b0;
    else if (m_ph != P_PW && ped)    m_pend = 1'b1;
    m_age = (nxt != m_ph) ? 0 : m_age + 1;
    m_ph  = nxt;
  endtask

  task automatic check_now();
    logic safe;
    safe = !((main != R) && (cntry != R)) && !(walk && ((main != R) || (cntry != R)));
    chk("lamps_vs_model", {main, cntry, walk}, model_lamps(m_ph));
    chk("safety_invariant", {4'd0, safe}, 5'd1);
    foreach (spots[i]) begin
      if (spots[i].c == cyc) chk("timeline", {main, cntry, walk}, {spots[i].m, spots[i].k, spots[i].w});
    end
  endtask

  // Called #1 after a rising edge (or release): drive, check mid-cycle, advance.
  task automatic step(input bit car, input bit ped, input bit em);
    car_cntry = car; ped_req = ped; emerg = em;
    @(negedge clock);
    check_now();
    model_step(car, ped, em);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    car_cntry = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    clear = 1'b0;
    #2;
    chk("reset_lamps", {main, cntry, walk}, {G, R, 1'b0});
    chk("reset_phase", {2'd0, phase}, {2'd0, MAIN_GRN});
    @(posedge clock);
    #1;
    clear = 1'b1;
    model_reset();
    cyc = 0;
    spots.delete();
  endtask

  task automatic add(input int c, input logic [1:0] m, input logic [1:0] k, input logic w);
    spot_t s;
    s.c = c; s.m = m; s.k = k; s.w = w;
    spots.push_back(s);
  endtask

  initial begin
    bit rc, rp, re;
    clear = 1'b0; car_cntry = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // 1: idle, main rests on green.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i % 20 == 0) chk("idle_phase", {2'd0, phase}, {2'd0, MAIN_GRN});
    end

    // 2: country car held from cycle 2, capped at MAX_GREEN.
    do_reset();
    add(7, G, R, 0); add(8, Y, R, 0); add(10, Y, R, 0); add(11, R, R, 0);
    add(13, R, G, 0); add(28, R, G, 0); add(29, R, Y, 0); add(31, R, Y, 0);
    add(32, R, R, 0); add(33, R, R, 0); add(34, G, R, 0);
    for (int i = 0; i < 36; i++) step(i >= 2, 1'b0, 1'b0);

    // 3: ped pulse at 3, second pulse during walk is dropped.
    do_reset();
    add(7, G, R, 0); add(8, Y, R, 0); add(11, R, R, 0); add(13, R, R, 1);
    add(22, R, R, 1); add(23, R, R, 0); add(25, G, R, 0); add(40, G, R, 0);
    for (int i = 0; i < 42; i++) step(1'b0, (i == 3) || (i == 15), 1'b0);

    // 4: car and ped together; country first, then walk, then main.
    do_reset();
    add(13, R, G, 0); add(20, R, G, 0); add(21, R, Y, 0); add(24, R, R, 0);
    add(26, R, R, 1); add(35, R, R, 1); add(36, R, R, 0); add(38, G, R, 0);
    for (int i = 0; i < 40; i++) step((i >= 1) && (i < 12), i == 1, 1'b0);

    // 5: emergency during country green, main held despite the car.
    do_reset();
    add(15, R, G, 0); add(16, R, Y, 0); add(18, R, Y, 0); add(19, R, R, 0);
    add(21, G, R, 0); add(40, G, R, 0);
    for (int i = 0; i < 42; i++) step(i >= 2, 1'b0, i >= 15);

    // 6: async clear mid country-yellow with a pedestrian pending.
    do_reset();
    add(29, R, Y, 0); add(30, R, Y, 0);
    for (int i = 0; i < 30; i++) step(i >= 2, i == 20, 1'b0);
    car_cntry = 1'b1; ped_req = 1'b0; emerg = 1'b0;
    @(negedge clock);
    check_now();
    #1 clear = 1'b0;
    #1 chk("midphase_clear", {main, cntry, walk}, {G, R, 1'b0});
    chk("midphase_clear_phase", {2'd0, phase}, {2'd0, MAIN_GRN});
    clear = 1'b1;
    car_cntry = 1'b0;
    model_reset();
    spots.delete();
    @(posedge clock);
    #1;
    cyc = 0;
    add(20, G, R, 0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    do_reset();
    rc = 1'b0; re = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) rc = ~rc;
      if ($urandom_range(59, 0) == 0) re = ~re;
      rp = ($urandom_range(24, 0) == 0);
      step(rc, rp, re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
